fft_tx_sequencer: RTL and testbench
===================================

# fft_tx_sequencer

Synchronous frame sequencer between the FFT core and the UART transmitter. When the FFT core signals a finished transform, the block snapshots all real-part outputs and streams them to the UART transmitter as one framed packet. The packet is a header byte, 2*FFT_SIZE payload bytes (word 0 first, low byte first) and an XOR checksum byte. It paces itself on the transmitter's per-byte done pulse, so no asynchronous edges are used anywhere in the TX path.

## Interface
- FFT_SIZE, 16, number of FFT result words per frame
- WORD_SIZE, 16, bits per result word; fixed at 2*DATA_LENGTH
- DATA_LENGTH, 8, UART byte width
- HEADER, 8'hA5, frame start byte
---
- i_clk  in  1  system clock; single clock domain
- i_rst  in  1  synchronous, active-low reset
- i_results_valid  in  1  one-cycle pulse from FFT core: i_results is valid this cycle
- i_results  in  FFT_SIZE*WORD_SIZE  flat real-part bus; word k at bits [k*WORD_SIZE +: WORD_SIZE]
- i_tx_done  in  1  one-cycle pulse from UART transmitter: current byte fully shifted out
- o_tx_start  out  1  one-cycle pulse: UART transmitter loads o_tx_byte
- o_tx_byte  out  DATA_LENGTH  byte to transmit; stable from the o_tx_start cycle until i_tx_done
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse after the checksum byte's i_tx_done
- o_overrun  out  1  one-cycle pulse: i_results_valid arrived while busy and was dropped

## Operation
- States:
  - IDLE: o_busy=0.
  - SEND: o_tx_start pulses and o_tx_byte is driven.
  - WAIT: waiting for i_tx_done.
  - DONE: o_frame_done pulses, then return to IDLE.
- IDLE, i_results_valid=1: register i_results into a snapshot; clear the byte index and the checksum; go to SEND.
- Byte index n runs 0..2*FFT_SIZE+1 (6 bits at default sizes):
  - n=0: HEADER.
  - n=1..2*FFT_SIZE: payload byte n-1, taken from word (n-1)>>1. Even (n-1) selects the low byte, odd (n-1) the high byte.
  - n=2*FFT_SIZE+1: checksum, the XOR of all payload bytes; HEADER is excluded.
- SEND: assert o_tx_start for exactly one cycle, present the byte, fold payload bytes into the checksum, go to WAIT.
- WAIT, i_tx_done=1:
  - If n is the last index, go to DONE.
  - Otherwise increment n and go to SEND.
- DONE: pulse o_frame_done, go to IDLE.
- i_results_valid while not IDLE: ignored, snapshot unchanged, o_overrun pulses the next cycle.
- i_tx_done in IDLE, SEND or DONE: ignored.
- i_results_valid and i_tx_done in the same cycle while busy: the done pulse is processed normally and o_overrun pulses.
- Snapshot changes only on an accepted i_results_valid. FFT outputs may change freely during transmission.

## Timing
- Reset (i_rst=0 at a clock edge): state IDLE, n=0, checksum 0. o_tx_start, o_busy, o_frame_done and o_overrun are 0; o_tx_byte is 8'h00.
- Reset takes priority over all inputs, including mid-frame. No further o_tx_start follows until a new i_results_valid.
- i_results_valid sampled at edge k: o_busy=1 and o_tx_start=1 with o_tx_byte=HEADER after edge k, i.e. in cycle k+1.
- i_tx_done sampled at edge m (not last byte): next o_tx_start pulse in cycle m+1. Each byte costs one cycle plus the UART byte time.
- Last i_tx_done at edge m: o_frame_done=1 in cycle m+1. o_busy falls after edge m+1. A new i_results_valid is accepted at edge m+2 or later.
- o_tx_byte is registered and changes only on SEND entry or reset.
- At most one o_tx_start is outstanding at any time.

## Test plan
- Reset, then all words 0x0000 and a valid pulse; bench returns i_tx_done 10 cycles after each start. Required: 34 bytes A5, 32×00, 00; o_frame_done once; o_busy high from the cycle after valid until the cycle after frame_done.
- Word0=0x1234, rest 0. Required: A5 34 12 00…00, checksum 0x26. Also change i_results mid-frame and verify the bytes still come from the snapshot.
- Word k = k+1 (k=0..15). Required: payload 01 00 02 00 … 10 00, checksum 0x10.
- Second valid pulse at byte 5 of a frame, coincident with i_tx_done. Required: o_overrun pulses once, byte 6 starts normally, frame contents unchanged.
- i_rst=0 for one cycle while waiting on byte 12. Required: all outputs 0 next cycle; stray i_tx_done pulses are ignored; a new valid produces a complete fresh 34-byte frame starting with A5.
- Spurious i_tx_done pulses in IDLE and in the o_tx_start cycle. Required: no extra starts and no index advance.

Source files
------------

// File: rtl/fft_tx_sequencer.sv
// Frames one snapshot of FFT real-part results into a UART packet:
// header, payload bytes (word 0 first, low byte first), then the XOR checksum.
module fft_tx_sequencer #(
   parameter int FFT_SIZE    = 16,
   parameter int WORD_SIZE   = 16,
   parameter int DATA_LENGTH = 8,
   parameter logic [DATA_LENGTH-1:0] HEADER = 8'hA5
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_results_valid,
   input  logic [FFT_SIZE*WORD_SIZE-1:0] i_results,
   input  logic                          i_tx_done,
   output logic                          o_tx_start,
   output logic [DATA_LENGTH-1:0]        o_tx_byte,
   output logic                          o_busy,
   output logic                          o_frame_done,
   output logic                          o_overrun
);

   localparam int NBYTES = 2 * FFT_SIZE;
   localparam int IDX_W  = $clog2(NBYTES + 2);
   localparam int PAY_W  = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                        state;
   state_t                        state_nx;
   logic [IDX_W-1:0]              idx;
   logic [DATA_LENGTH-1:0]        csum;
   logic [DATA_LENGTH-1:0]        tx_byte;
   logic [FFT_SIZE*WORD_SIZE-1:0] snap;
   logic                          overrun;
   logic                          accept;
   logic                          advance;

   // Payload byte p (p = n-1) sits at bits [p*DATA_LENGTH +: DATA_LENGTH] of the
   // snapshot because words are two bytes with the low byte at the lower address.
   function automatic logic [DATA_LENGTH-1:0] frame_byte(
      input logic [IDX_W-1:0]              n,
      input logic [FFT_SIZE*WORD_SIZE-1:0] s,
      input logic [DATA_LENGTH-1:0]        c
   );
      logic [IDX_W-1:0] p;
      logic [PAY_W-1:0] pi;
      p  = n - 1'b1;
      pi = p[PAY_W-1:0];
      if (n == '0)
         return HEADER;
      else if (n == LAST_IDX)
         return c;
      else
         return s[pi*DATA_LENGTH +: DATA_LENGTH];
   endfunction

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      advance  = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_results_valid) begin
               accept   = 1'b1;
               state_nx = S_SEND;
            end
         end
         S_SEND: state_nx = S_WAIT;
         S_WAIT: begin
            if (i_tx_done) begin
               if (idx == LAST_IDX) begin
                  state_nx = S_DONE;
               end else begin
                  advance  = 1'b1;
                  state_nx = S_SEND;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Control and the registered byte output; the checksum folds each payload
   // byte during its SEND cycle, so it is complete before the checksum byte loads.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         csum    <= '0;
         tx_byte <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nx;
         overrun <= i_results_valid && (state != S_IDLE);
         if (accept) begin
            idx     <= '0;
            csum    <= '0;
            tx_byte <= HEADER;
         end else if (advance) begin
            idx     <= idx + 1'b1;
            tx_byte <= frame_byte(idx + 1'b1, snap, csum);
         end else if (state == S_SEND && idx != '0 && idx != LAST_IDX) begin
            csum <= csum ^ tx_byte;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept && i_rst)
         snap <= i_results;
   end

   assign o_tx_start   = (state == S_SEND);
   assign o_tx_byte    = tx_byte;
   assign o_busy       = (state != S_IDLE);
   assign o_frame_done = (state == S_DONE);
   assign o_overrun    = overrun;

endmodule

// File: tb/tb_fft_tx_sequencer.sv
// Directed bench for fft_tx_sequencer: a table of frames served by a UART
// model that answers each start with a done pulse ten cycles later.
module tb_fft_tx_sequencer;

   localparam int FFT_SIZE = 16;
   localparam int NB       = 2 * FFT_SIZE + 2;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic         i_results_valid = 1'b0;
   logic [255:0] i_results = '0;
   logic         i_tx_done = 1'b0;
   logic         o_tx_start;
   logic [7:0]   o_tx_byte;
   logic         o_busy;
   logic         o_frame_done;
   logic         o_overrun;

   fft_tx_sequencer dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_results_valid (i_results_valid),
      .i_results       (i_results),
      .i_tx_done       (i_tx_done),
      .o_tx_start      (o_tx_start),
      .o_tx_byte       (o_tx_byte),
      .o_busy          (o_busy),
      .o_frame_done    (o_frame_done),
      .o_overrun       (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string        name;
      logic [255:0] res;
      logic [7:0]   csum;
      logic [7:0]   b1;
      logic [7:0]   b2;
      logic [7:0]   b31;
      logic [7:0]   b32;
      int           ovr_at;
      int           spur_at;
      bit           mid_chg;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] cap[$];
   int         total = 0;
   int         bad = 0;
   int         fd_cnt, ov_cnt, dbl_cnt, gap_cnt, unst_cnt;
   bit         outstanding = 1'b0;
   bit         in_frame = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and log what the DUT shows there.
   task automatic tick();
      @(negedge i_clk);
      if (o_tx_start) begin
         if (outstanding) dbl_cnt++;
         outstanding = 1'b1;
         cap.push_back(o_tx_byte);
      end else if (outstanding && cap.size() > 0 && o_tx_byte !== cap[$]) begin
         unst_cnt++;
      end
      if (o_frame_done) fd_cnt++;
      if (o_overrun) ov_cnt++;
      if (in_frame && !o_busy) gap_cnt++;
   endtask

   task automatic run_frame(input vec_t v, input int stop_at);
      int   waited;
      bit   timed_out;
      int   mism;
      cap.delete();
      fd_cnt = 0; ov_cnt = 0; dbl_cnt = 0; gap_cnt = 0; unst_cnt = 0;
      timed_out = 1'b0;
      i_results = v.res;
      i_results_valid = 1'b1;
      tick();
      i_results_valid = 1'b0;
      check({v.name, "_start_latency"}, longint'({o_busy, o_tx_start, o_tx_byte}), longint'({2'b11, 8'hA5}));
      in_frame = 1'b1;
      for (int b = 0; b < NB; b++) begin
         waited = 0;
         while (!o_tx_start && waited < 50) begin
            tick();
            waited++;
         end
         if (!o_tx_start) begin
            total++;
            bad++;
            $display("FAIL %s_start_timeout: byte %0d no start after %0d cycles, want start", v.name, b, waited);
            timed_out = 1'b1;
            break;
         end
         if (b == stop_at) begin
            in_frame = 1'b0;
            return;
         end
         if (b == v.spur_at) begin
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
            repeat (9) tick();
         end else begin
            repeat (10) tick();
         end
         if (b == 3 && v.mid_chg) i_results = ~v.res;
         if (b == v.ovr_at) begin
            i_results_valid = 1'b1;
            i_results = ~v.res;
         end
         i_tx_done = 1'b1;
         outstanding = 1'b0;
         tick();
         i_tx_done = 1'b0;
         i_results_valid = 1'b0;
         if (b == v.ovr_at)
            check({v.name, "_overrun_pulse"}, longint'(o_overrun), 1);
      end
      if (!timed_out) begin
         check({v.name, "_frame_done_cycle"}, longint'({o_frame_done, o_busy}), 3);
         in_frame = 1'b0;
         tick();
         check({v.name, "_busy_fall"}, longint'({o_frame_done, o_busy}), 0);
      end
      in_frame = 1'b0;
      check({v.name, "_byte_count"}, longint'(cap.size()), NB);
      if (cap.size() == NB) begin
         mism = 0;
         for (int b = 1; b <= 2 * FFT_SIZE; b++)
            if (cap[b] !== v.res[(b-1)*8 +: 8]) mism++;
         check({v.name, "_header"}, longint'(cap[0]), 8'hA5);
         check({v.name, "_byte1"}, longint'(cap[1]), longint'(v.b1));
         check({v.name, "_byte2"}, longint'(cap[2]), longint'(v.b2));
         check({v.name, "_byte31"}, longint'(cap[31]), longint'(v.b31));
         check({v.name, "_byte32"}, longint'(cap[32]), longint'(v.b32));
         check({v.name, "_payload_mismatches"}, longint'(mism), 0);
         check({v.name, "_checksum"}, longint'(cap[NB-1]), longint'(v.csum));
      end
      check({v.name, "_frame_done_count"}, longint'(fd_cnt), 1);
      check({v.name, "_overrun_count"}, longint'(ov_cnt), (v.ovr_at >= 0) ? 1 : 0);
      check({v.name, "_double_start"}, longint'(dbl_cnt), 0);
      check({v.name, "_busy_gaps"}, longint'(gap_cnt), 0);
      check({v.name, "_byte_unstable"}, longint'(unst_cnt), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] ramp;
      int           n0;
      ramp = '0;
      for (int k = 0; k < FFT_SIZE; k++) ramp[k*16 +: 16] = 16'(k + 1);
      vecs[0] = '{"zeros", '0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1, 1'b0};
      vecs[1] = '{"w0_1234", 256'h1234, 8'h26, 8'h34, 8'h12, 8'h00, 8'h00, -1, 2, 1'b1};
      vecs[2] = '{"ramp", ramp, 8'h10, 8'h01, 8'h00, 8'h10, 8'h00, -1, -1, 1'b0};
      vecs[3] = '{"ramp_ovr", ramp, 8'h10, 8'h01, 8'h00, 8'h10, 8'h00, 5, -1, 1'b0};

      // Reset, then spurious done pulses in IDLE
      repeat (3) tick();
      check("reset_outputs", longint'({o_tx_start, o_busy, o_frame_done, o_overrun, o_tx_byte}), 0);
      i_rst = 1'b1;
      tick();
      check("post_reset_idle", longint'({o_tx_start, o_busy, o_frame_done, o_overrun, o_tx_byte}), 0);
      cap.delete();
      repeat (3) begin
         i_tx_done = 1'b1;
         tick();
         i_tx_done = 1'b0;
         tick();
      end
      check("idle_spurious_done_starts", longint'(cap.size()), 0);
      check("idle_spurious_done_busy", longint'(o_busy), 0);

      foreach (vecs[i]) run_frame(vecs[i], -1);

      // Reset while waiting on byte 12, then a fresh frame
      run_frame(vecs[2], 12);
      repeat (3) tick();
      i_rst = 1'b0;
      tick();
      i_rst = 1'b1;
      check("midframe_reset_outputs", longint'({o_tx_start, o_busy, o_frame_done, o_overrun, o_tx_byte}), 0);
      outstanding = 1'b0;
      n0 = cap.size();
      repeat (3) begin
         i_tx_done = 1'b1;
         tick();
         i_tx_done = 1'b0;
         repeat (2) tick();
      end
      check("after_reset_no_start", longint'(cap.size()), longint'(n0));
      check("after_reset_busy", longint'(o_busy), 0);
      run_frame(vecs[2], -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
